// File: rtl/rr_index_pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pulse_pkg
// Description : Shared types and helpers for the index-to-pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_pulse_pkg;

  // Per-channel pulse shaper states
  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_HIGH = 2'd1,
    PC_LOW  = 2'd2
  } pulse_state_t;

  // Larger of two integers, used to size the per-channel counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_index_pulse_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_index_pulse_generator_if
// Description : Index handshake plus pulse/busy/err outputs of the generator.
//               master = index producer side, slave = generator side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_index_pulse_generator_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH);

  logic [LB_DATA_WIDTH-1:0] index;
  logic                     valid;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [DATA_WIDTH-1:0]    busy;
  logic                     err;

  modport master (
    output index, valid,
    input  ready, out_data, busy, err
  );

  modport slave (
    input  index, valid,
    output ready, out_data, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/rr_index_pulse_generator_channel.sv
`default_nettype none
// ============================================================================
// Module      : rr_pulse_channel
// Description : One output channel. A start request produces HIGH_CYCLES of
//               pulse followed by LOW_CYCLES of enforced low time before the
//               channel reports idle again. Outputs are registered from the
//               next state so they line up with the state register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pulse_channel
  import rr_pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic pulse,
  output logic busy,
  output logic idle
);

  localparam int CNT_WIDTH = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [CNT_WIDTH-1:0] HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOW_LOAD  = CNT_WIDTH'(LOW_CYCLES - 1);

  pulse_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, busy_q, idle_q;

  // Next-state and counter progression; counter only ever counts down to 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PC_IDLE: begin
        if (start) begin
          state_d = PC_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      PC_HIGH: begin
        if (cnt_q == '0) begin
          state_d = PC_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PC_LOW: begin
        if (cnt_q == '0) begin
          state_d = PC_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = PC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset truncates any pulse at once
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= PC_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= (state_d == PC_HIGH);
      busy_q  <= (state_d != PC_IDLE);
      idle_q  <= (state_d == PC_IDLE);
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign idle  = idle_q;

endmodule
`default_nettype wire

// File: rtl/rr_index_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : rr_index_pulse_generator
// Description : Accepts channel indices over valid/ready and fires one shaped
//               pulse on the addressed output bit. A channel stalls its own
//               index until its pulse and low gap are complete; indices beyond
//               the channel count are always accepted, dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_index_pulse_generator
  import rr_pulse_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  rr_index_pulse_generator_if.slave   bus
);

  localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH);
  localparam int IDX_SPAN      = 1 << LB_DATA_WIDTH;

  logic [DATA_WIDTH-1:0] start_vec;
  logic [DATA_WIDTH-1:0] pulse_vec;
  logic [DATA_WIDTH-1:0] busy_vec;
  logic [DATA_WIDTH-1:0] idle_vec;
  logic [IDX_SPAN-1:0]   idle_ext;
  logic                  oor;
  logic                  err_q;

  // Out-of-range indices only exist when the channel count is not a power of 2
  generate
    if (IDX_SPAN == DATA_WIDTH) begin : g_range_full
      assign oor = 1'b0;
    end else begin : g_range_partial
      assign oor = (bus.index > LB_DATA_WIDTH'(DATA_WIDTH - 1));
    end
  endgenerate

  // Widen the idle vector to the full index space so the ready mux never
  // selects past the end; unused slots read as not-idle but oor covers them
  always_comb begin
    idle_ext                 = '0;
    idle_ext[DATA_WIDTH-1:0] = idle_vec;
  end

  assign bus.ready = oor | idle_ext[bus.index];

  // One-hot start decode and one shaper per output bit
  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chan
      assign start_vec[i] = bus.valid & idle_vec[i] &
                            (bus.index == LB_DATA_WIDTH'(i));

      rr_pulse_channel #(
        .HIGH_CYCLES (HIGH_CYCLES),
        .LOW_CYCLES  (LOW_CYCLES)
      ) u_chan (
        .clk   (clk),
        .rstn  (rstn),
        .start (start_vec[i]),
        .pulse (pulse_vec[i]),
        .busy  (busy_vec[i]),
        .idle  (idle_vec[i])
      );
    end
  endgenerate

  // One-cycle error strobe for a discarded out-of-range index
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bus.valid & oor;
    end
  end

  assign bus.out_data = pulse_vec;
  assign bus.busy     = busy_vec;
  assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_index_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_index_pulse_generator
// Description : Bench for the index pulse generator. An 8-channel and a
//               6-channel instance share one index/valid stimulus; each is
//               compared to a model that records the edge at which every
//               channel was last started and derives outputs from elapsed time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_index_pulse_generator;

  localparam int H8 = 4;
  localparam int L8 = 2;
  localparam int H6 = 3;
  localparam int L6 = 1;
  localparam int NEVER = -100000;
  localparam int NCYC  = 2000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rr_index_pulse_generator_if #(.DATA_WIDTH(8)) bus8 ();
  rr_index_pulse_generator_if #(.DATA_WIDTH(6)) bus6 ();

  rr_index_pulse_generator #(
    .DATA_WIDTH (8), .HIGH_CYCLES (H8), .LOW_CYCLES (L8)
  ) u_dut8 (
    .clk (clk), .rstn (rstn), .bus (bus8.slave)
  );

  rr_index_pulse_generator #(
    .DATA_WIDTH (6), .HIGH_CYCLES (H6), .LOW_CYCLES (L6)
  ) u_dut6 (
    .clk (clk), .rstn (rstn), .bus (bus6.slave)
  );

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int acc8[8];
  int acc6[6];
  bit err6_exp = 1'b0;
  logic [2:0] idx;
  logic       vld;
  int held_acc   = 0;
  int held_edges = 0;
  logic prev5    = 1'b0;
  logic [7:0] tbl [7] = '{8'h01, 8'h03, 8'h07, 8'h07, 8'h06, 8'h04, 8'h00};

  task automatic check_val(input string tag, input int cyc,
                           input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Channel started at edge n is in its window while 0 <= k-n < len
  function automatic bit in_win(input int kk, input int n, input int len);
    return ((kk - n) >= 0) && ((kk - n) < len);
  endfunction

  function automatic logic [7:0] exp_vec8(input int len);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = in_win(k, acc8[i], len);
    return v;
  endfunction

  function automatic logic [5:0] exp_vec6(input int len);
    logic [5:0] v = '0;
    for (int i = 0; i < 6; i++) v[i] = in_win(k, acc6[i], len);
    return v;
  endfunction

  function automatic bit exp_ready8(input logic [2:0] ix);
    return !in_win(k, acc8[ix], H8 + L8);
  endfunction

  function automatic bit exp_ready6(input logic [2:0] ix);
    if (ix >= 3'd6) return 1'b1;
    return !in_win(k, acc6[ix], H6 + L6);
  endfunction

  task automatic drive(input logic r, input logic v, input logic [2:0] ix);
    rstn       = r;
    vld        = v;
    idx        = ix;
    bus8.valid = v;
    bus8.index = ix;
    bus6.valid = v;
    bus6.index = ix;
  endtask

  initial begin
    bit a8, a6;
    for (int i = 0; i < 8; i++) acc8[i] = NEVER;
    for (int i = 0; i < 6; i++) acc6[i] = NEVER;
    drive(1'b0, 1'b0, 3'd0);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_val("out8",  c, 32'(bus8.out_data), 32'(exp_vec8(H8)));
      check_val("busy8", c, 32'(bus8.busy),     32'(exp_vec8(H8 + L8)));
      check_val("err8",  c, 32'(bus8.err),      32'd0);
      check_val("out6",  c, 32'(bus6.out_data), 32'(exp_vec6(H6)));
      check_val("busy6", c, 32'(bus6.busy),     32'(exp_vec6(H6 + L6)));
      check_val("err6",  c, 32'(bus6.err),      32'(err6_exp));

      if (c >= 16 && c <= 95) begin
        if (bus8.out_data[5] && !prev5) held_edges++;
      end
      prev5 = bus8.out_data[5];
      if (c == 96) check_val("held_edges", c, 32'(held_edges), 32'(held_acc));
      if (c >= 96 && c <= 102)
        check_val("burst012", c, 32'(bus8.out_data & 8'h07), 32'(tbl[c-96]));

      // Stimulus schedule
      if (c < 5)                      drive(1'b0, 1'b0, 3'd0);
      else if (c < 15)                drive(1'b1, 1'b0, 3'(c % 8));
      else if (c < 95)                drive(1'b1, 1'b1, 3'd5);
      else if (c < 98)                drive(1'b1, 1'b1, 3'(c - 95));
      else if (c < 111)               drive(1'b1, 1'b0, 3'(c % 8));
      else if (c == 111)              drive(1'b1, 1'b1, 3'd6);
      else if (c == 112)              drive(1'b1, 1'b0, 3'd6);
      else if (c == 113)              drive(1'b0, 1'b0, 3'd6);
      else if (c == 114)              drive(1'b1, 1'b1, 3'd6);
      else if (c < 120)               drive(1'b1, 1'b0, 3'd0);
      else
        drive(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));

      #1;
      check_val("ready8", c, 32'(bus8.ready), 32'(exp_ready8(idx)));
      check_val("ready6", c, 32'(bus6.ready), 32'(exp_ready6(idx)));

      @(posedge clk);
      a8 = rstn && vld && exp_ready8(idx);
      a6 = rstn && vld && exp_ready6(idx);
      k++;
      if (!rstn) begin
        for (int i = 0; i < 8; i++) acc8[i] = NEVER;
        for (int i = 0; i < 6; i++) acc6[i] = NEVER;
        err6_exp = 1'b0;
      end else begin
        if (a8) acc8[idx] = k;
        if (a6 && idx < 3'd6) acc6[idx] = k;
        err6_exp = vld && (idx >= 3'd6);
        if (c >= 15 && c < 95 && a8 && idx == 3'd5) held_acc++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_index_pulse_generator.md
Name: rr_index_pulse_generator

Overview:
- Reverse of the edge-to-index path: consumes a stream of channel indices over a valid/ready handshake and emits one clean pulse on the addressed bit of a parallel output vector.
- Each pulse is guaranteed a minimum high time and a minimum low gap afterwards, so a downstream rising-edge detector on each bit sees exactly one edge per accepted index.
- Sits between an index producer (arbiter, command decoder) and per-bit trigger/strobe lines.

Parameters:
- DATA_WIDTH, 8: number of output channels; must be ≥2.
- HIGH_CYCLES, 4: cycles each pulse stays high; must be ≥1.
- LOW_CYCLES, 2: minimum low cycles after a pulse before that channel re-arms; must be ≥1.
- LB_DATA_WIDTH, localparam $clog2(DATA_WIDTH): index width.
- CNT_WIDTH, localparam $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1): per-channel counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- index  in  LB_DATA_WIDTH  channel to pulse
- valid  in  1  index is valid
- ready  out  1  index accepted this cycle when valid&ready
- out_data  out  DATA_WIDTH  registered pulse outputs, one bit per channel
- busy  out  DATA_WIDTH  registered; bit i=1 while channel i is not IDLE
- err  out  1  registered one-cycle strobe; an out-of-range index was accepted and discarded

Behaviour:
- Reset: rstn sampled at posedge clk. While low, all channels go IDLE, counters=0, out_data=0, busy=0, err=0. Reset mid-pulse truncates the pulse immediately: out_data=0 on the next cycle. No pending work survives reset.
- Handshake:
  - ready is combinational: 1 if index ≥ DATA_WIDTH, else 1 iff channel[index] is IDLE.
  - ready may depend on index but never on valid.
  - Accept happens when valid&ready at a posedge.
  - A producer holding valid with an unchanged index must be stalled until that channel is IDLE; channels never queue requests.
- Per-channel FSM, states IDLE, HIGH, LOW:
  - IDLE -> HIGH on accept addressed to this channel; load cnt=HIGH_CYCLES-1.
  - HIGH: out_data[i]=1. If cnt==0, go to LOW and load cnt=LOW_CYCLES-1; else decrement cnt.
  - LOW: out_data[i]=0. If cnt==0, go to IDLE; else decrement cnt.
  - out_data[i] = (state==HIGH), registered.
  - busy[i] = (state!=IDLE), registered.
- Timing, for an accept at edge N:
  - out_data[i] is high for cycles N+1 .. N+HIGH_CYCLES.
  - It is low from N+HIGH_CYCLES+1 on.
  - The channel is IDLE and ready in cycle N+HIGH_CYCLES+LOW_CYCLES+1.
  - Back-to-back requests to the same channel therefore see a low gap of LOW_CYCLES+1 cycles.
- Independence: channels run concurrently. At most one accept per cycle, so at most one channel starts per cycle. Pulses on different channels may overlap freely.
- Out-of-range index (only possible when DATA_WIDTH is not a power of 2):
  - Always accepted and dropped.
  - err=1 for exactly the cycle after the accept; no channel state changes.
- valid=0: no state change beyond counter progression; index is ignored.
- Counters never wrap. Arithmetic is unsigned, CNT_WIDTH bits wide. The load values HIGH_CYCLES-1 and LOW_CYCLES-1 fit by construction.

Decomposition:
- Shared package rr_pulse_pkg holds:
  - typedef enum logic [1:0] {PC_IDLE, PC_HIGH, PC_LOW} pulse_state_t;
  - helper function max_int for CNT_WIDTH.
- Sub-module rr_pulse_channel, instantiated DATA_WIDTH times in a generate loop:
  - Inputs: clk, rstn, start.
  - Outputs: pulse, busy, idle.
  - Parameters: HIGH_CYCLES, LOW_CYCLES.
- Top level owns the ready mux, index decode to a one-hot start vector, and the err register.

Test Plan:
- Reset then idle (DATA_WIDTH=8, HIGH_CYCLES=4, LOW_CYCLES=2): out_data=0, busy=0, err=0, ready=1 for all index values.
- Single accept of index=3 at edge N: out_data=8'h08 for cycles N+1..N+4, then 0. busy[3]=1 for N+1..N+6. ready for index=3 is 0 during N+1..N+6 and returns to 1 at N+7.
- valid held with index=5 continuously: pulses are 4 high / 3 low, repeating every 7 cycles. Exactly one rising edge per accept, counted over 10 accepts.
- Accepts of indices 0,1,2 on consecutive cycles: out_data goes 01, 03, 07, 07, 06, 04, 00 starting at N+1. All three channels are busy in parallel and no request is stalled.
- rstn driven low at the 2nd high cycle of a channel-6 pulse: out_data=0 and busy=0 the next cycle. After reset releases, index=6 is accepted immediately.
- DATA_WIDTH=6, index=7 with valid: ready=1, err=1 for exactly one cycle, out_data unchanged, busy unchanged.
